dequantization: RTL and testbench

//  Inverse of the CNN requantizer: maps a 9-bit signed quantized activation back to the
//  32-bit accumulator domain, result = sat32(round((x - zp) * Q / 2^31 * 2^EXP)).

---
 rtl/dequantization_pkg.sv | 29 ++
 rtl/dequantization_round_sat.sv | 29 ++
 rtl/dequantization.sv | 111 +++++++++++
 tb/tb_dequantization.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dequantization_pkg.sv
// Shared types and constants for the dequantizer: FSM state encoding, Q31 rounding
// constants, int32 limits and the default scale pairing used with the quantizer.
package dequantization_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SUB   = 3'd1,
        ST_MUL   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_ROUND = 3'd4,
        ST_SAT   = 3'd5,
        ST_OUT   = 3'd6
    } state_t;

    localparam int                 Q_FRAC     = 31;
    localparam logic signed [71:0] ROUND_HALF = 72'sh0000_0000_0040_0000_00;
    localparam logic [31:0]        INT32_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0]        INT32_MIN  = 32'h8000_0000;

    localparam logic [30:0]        DEF_Q_VAL   = 31'd1144516732;
    localparam logic [4:0]         DEF_EXP_VAL = 5'd9;
    localparam logic signed [8:0]  DEF_ZP_VAL  = 9'sd0;

    // A 41-bit value fits int32 when its top ten bits are all copies of the sign.
    function automatic logic fits_int32(input logic [40:0] v);
        return (v[40:31] == {10{v[40]}});
    endfunction

endpackage

// File: rtl/dequantization_round_sat.sv
// Combinational Q31 round-half-up and int32 saturation, shared by rescale blocks.
// The parent registers each result in its own pipeline state.
module dequantization_round_sat
    import dequantization_pkg::*;
(
    input  logic [71:0] shifted,
    input  logic [40:0] rounded_in,
    output logic [40:0] rounded,
    output logic [31:0] sat_data,
    output logic        sat_flag
);

    logic signed [71:0] biased;

    always_comb begin
        biased  = $signed(shifted) + ROUND_HALF;
        rounded = 41'(biased >>> Q_FRAC);
    end

    always_comb begin
        sat_data = rounded_in[31:0];
        sat_flag = 1'b0;
        if (!fits_int32(rounded_in)) begin
            sat_flag = 1'b1;
            sat_data = rounded_in[40] ? INT32_MIN : INT32_MAX;
        end
    end

endmodule

// File: rtl/dequantization.sv
// Multi-cycle dequantizer: int9 activation back to the int32 accumulator domain,
// sat32(round((x - zp) * Q / 2^31 * 2^EXP)), one operation in flight.
module dequantization
    import dequantization_pkg::*;
#(
    parameter logic [30:0]       DEF_Q   = DEF_Q_VAL,
    parameter logic [4:0]        DEF_EXP = DEF_EXP_VAL,
    parameter logic signed [8:0] DEF_ZP  = DEF_ZP_VAL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [30:0] cfg_q,
    input  logic [4:0]  cfg_exp,
    input  logic [8:0]  cfg_zp,
    input  logic [8:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_sat,
    output logic        out_valid,
    input  logic        out_ready
);

    state_t state, state_next;

    logic [8:0]  x_reg;
    logic [8:0]  zp_reg;
    logic [30:0] q_reg;
    logic [4:0]  exp_reg;
    logic [9:0]  d_reg;
    logic [40:0] p_reg;
    logic [71:0] s_reg;
    logic [40:0] r_reg;

    logic [40:0] rounded;
    logic [31:0] sat_data;
    logic        sat_flag;

    dequantization_round_sat u_round_sat (
        .shifted    (s_reg),
        .rounded_in (r_reg),
        .rounded    (rounded),
        .sat_data   (sat_data),
        .sat_flag   (sat_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_SUB;
            end
            ST_SUB:   state_next = ST_MUL;
            ST_MUL:   state_next = ST_SHIFT;
            ST_SHIFT: state_next = ST_ROUND;
            ST_ROUND: state_next = ST_SAT;
            ST_SAT:   state_next = ST_OUT;
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Operands are sign-extended by hand so every product/shift is done at full
    // width; the low bits of an unsigned multiply equal the two's-complement product.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg    <= '0;
            zp_reg   <= DEF_ZP;
            q_reg    <= DEF_Q;
            exp_reg  <= DEF_EXP;
            d_reg    <= '0;
            p_reg    <= '0;
            s_reg    <= '0;
            r_reg    <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_reg   <= in_data;
                        zp_reg  <= cfg_zp;
                        q_reg   <= cfg_q;
                        exp_reg <= cfg_exp;
                    end
                end
                ST_SUB:   d_reg <= {x_reg[8], x_reg} - {zp_reg[8], zp_reg};
                ST_MUL:   p_reg <= {{31{d_reg[9]}}, d_reg} * {10'd0, q_reg};
                ST_SHIFT: s_reg <= {{31{p_reg[40]}}, p_reg} << exp_reg;
                ST_ROUND: r_reg <= rounded;
                ST_SAT: begin
                    out_data <= sat_data;
                    out_sat  <= sat_flag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dequantization.sv
// Self-checking bench for dequantization: directed table, randomized vectors against
// an arithmetic reference model, and handshake/reset/streaming sequences.
module tb_dequantization;

    logic        clk;
    logic        rst;
    logic [30:0] cfg_q;
    logic [4:0]  cfg_exp;
    logic [8:0]  cfg_zp;
    logic [8:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;

    int n_vectors;
    int n_miscompares;

    dequantization dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_q     (cfg_q),
        .cfg_exp   (cfg_exp),
        .cfg_zp    (cfg_zp),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [8:0] x;
        logic signed [8:0] zp;
        logic [30:0]       q;
        logic [4:0]        e;
        logic [31:0]       data;
        logic              sat;
    } vec_t;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference: value*2^e/2^31 rounded half-up equals floor((val + 2^(30-e)) / 2^(31-e)).
    function automatic void refModel(input int x, input int zp, input longint q, input int e,
                                     output logic [31:0] data, output logic sat);
        longint val;
        longint res;
        longint num;
        longint den;
        val = longint'(x - zp) * q;
        if (e == 31) begin
            res = val;
        end else begin
            num = val + (64'sd1 <<< (30 - e));
            den = 64'sd1 <<< (31 - e);
            res = num / den;
            if ((num % den != 0) && (num < 0)) res = res - 1;
        end
        if (res > 64'sd2147483647) begin
            data = 32'h7FFF_FFFF; sat = 1'b1;
        end else if (res < -64'sd2147483648) begin
            data = 32'h8000_0000; sat = 1'b1;
        end else begin
            data = res[31:0]; sat = 1'b0;
        end
    endfunction

    // Called at #1 after a posedge; performs one full transaction with immediate out_ready.
    task automatic applyStimulus(input logic signed [8:0] x, input logic signed [8:0] zp,
                                 input logic [30:0] q, input logic [4:0] e,
                                 output int lat, output logic [31:0] data, output logic sat);
        int waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(posedge clk); #1; waitc++;
        end
        checkOutput("in_ready_idle", {63'd0, in_ready}, 64'd1);
        in_data = x; cfg_zp = zp; cfg_q = q; cfg_exp = e; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        data = out_data; sat = out_sat;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        tbl[10];
        int          lat;
        logic [31:0] got_data;
        logic        got_sat;
        logic [31:0] exp_data;
        logic        exp_sat;
        logic signed [8:0] rx;
        logic signed [8:0] rzp;
        logic [30:0] rq;
        logic [4:0]  re;
        int          highs;
        int          xs;
        logic        acc;
        logic [31:0] outs[$];
        int          times[$];

        tbl[0] = '{9'sd10,   9'sd0,  31'h4000_0000, 5'd8,  32'd1280,       1'b0};
        tbl[1] = '{-9'sd3,   9'sd0,  31'h4000_0000, 5'd0,  32'hFFFF_FFFF,  1'b0};
        tbl[2] = '{9'sd3,    9'sd0,  31'h4000_0000, 5'd0,  32'd2,          1'b0};
        tbl[3] = '{9'sd255,  9'sd0,  31'h7FFF_FFFF, 5'd31, 32'h7FFF_FFFF,  1'b1};
        tbl[4] = '{-9'sd256, 9'sd0,  31'h7FFF_FFFF, 5'd31, 32'h8000_0000,  1'b1};
        tbl[5] = '{9'sd77,   9'sd5,  31'd0,         5'd20, 32'd0,          1'b0};
        tbl[6] = '{-9'sd1,   9'sd0,  31'h4000_0000, 5'd0,  32'd0,          1'b0};
        tbl[7] = '{9'sd1,    9'sd0,  31'h7FFF_FFFF, 5'd31, 32'h7FFF_FFFF,  1'b0};
        tbl[8] = '{-9'sd2,   9'sd0,  31'h4000_0000, 5'd31, 32'h8000_0000,  1'b0};
        tbl[9] = '{9'sd2,    9'sd0,  31'h4000_0000, 5'd31, 32'h7FFF_FFFF,  1'b1};

        n_vectors = 0; n_miscompares = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; cfg_q = '0; cfg_exp = '0; cfg_zp = '0;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_in_ready",  {63'd0, in_ready},  64'd1);
        checkOutput("reset_out_data",  {32'd0, out_data},  64'd0);
        checkOutput("reset_out_sat",   {63'd0, out_sat},   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].x, tbl[i].zp, tbl[i].q, tbl[i].e, lat, got_data, got_sat);
            checkOutput($sformatf("tbl%0d_data", i), {32'd0, got_data}, {32'd0, tbl[i].data});
            checkOutput($sformatf("tbl%0d_sat", i),  {63'd0, got_sat},  {63'd0, tbl[i].sat});
            checkOutput($sformatf("tbl%0d_lat", i),  64'(lat), 64'd5);
        end

        for (int i = 0; i < 40; i++) begin
            rx = 9'($urandom); rzp = 9'($urandom);
            rq = 31'($urandom); re = 5'($urandom);
            refModel(int'(rx), int'(rzp), longint'(rq), int'(re), exp_data, exp_sat);
            applyStimulus(rx, rzp, rq, re, lat, got_data, got_sat);
            checkOutput($sformatf("rnd%0d_data x=%0d zp=%0d q=%0h e=%0d", i, rx, rzp, rq, re),
                        {32'd0, got_data}, {32'd0, exp_data});
            checkOutput($sformatf("rnd%0d_sat", i), {63'd0, got_sat}, {63'd0, exp_sat});
        end

        // Backpressure: result must hold while out_ready is low; cfg changes after accept ignored.
        in_data = 9'sd5; cfg_zp = -9'sd3; cfg_q = 31'h4000_0000; cfg_exp = 5'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_q = 31'd0; cfg_exp = 5'd31; cfg_zp = 9'sd100; in_data = 9'sd0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checkOutput("bp_lat", 64'(lat), 64'd5);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("bp_hold%0d_valid", i), {63'd0, out_valid}, 64'd1);
            checkOutput($sformatf("bp_hold%0d_data", i),  {32'd0, out_data},  64'd16);
            checkOutput($sformatf("bp_hold%0d_in_ready", i), {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp_after_valid",    {63'd0, out_valid}, 64'd0);
        checkOutput("bp_after_in_ready", {63'd0, in_ready},  64'd1);
        checkOutput("bp_after_data",     {32'd0, out_data},  64'd16);

        // Reset during MUL aborts the operation.
        in_data = 9'sd100; cfg_zp = 9'sd0; cfg_q = 31'h4000_0000; cfg_exp = 5'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_abort_in_ready", {63'd0, in_ready}, 64'd1);
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) highs++;
            @(posedge clk); #1;
        end
        checkOutput("rst_abort_no_valid", 64'(highs), 64'd0);
        applyStimulus(9'sd1, 9'sd0, 31'h4000_0000, 5'd1, lat, got_data, got_sat);
        checkOutput("post_rst_data", {32'd0, got_data}, 64'd1);
        checkOutput("post_rst_lat",  64'(lat), 64'd5);

        // Streaming with in_valid held high and out_ready held high.
        xs = 1; in_data = 9'sd1; cfg_zp = 9'sd0; cfg_q = 31'h4000_0000; cfg_exp = 5'd2;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            acc = in_ready && in_valid;
            @(posedge clk); #1;
            if (acc) begin
                if (xs < 4) begin
                    xs++;
                    in_data = 9'(xs);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                outs.push_back(out_data);
                times.push_back(cyc);
            end
        end
        out_ready = 1'b0;
        checkOutput("stream_count", 64'(outs.size()), 64'd4);
        for (int i = 0; i < outs.size(); i++) begin
            checkOutput($sformatf("stream%0d_data", i), {32'd0, outs[i]}, 64'(2 * (i + 1)));
            if (i > 0)
                checkOutput($sformatf("stream%0d_gap", i), 64'(times[i] - times[i-1]), 64'd7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
